// File: rtl/bcd_time_counter.sv
// Packed-BCD hh:mm:ss.cc timekeeper with prescaler, run/stop, clear and validated load.
// Optional ALARM_EN adds an alarm register and an alarm_hit pulse on matching increments.
module bcd_time_counter #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] set_value,
`ifdef ALARM_EN
  input  logic        alarm_set,
  output logic        alarm_hit,
`endif
  output logic [31:0] display,
  output logic        tick,
  output logic        day_wrap,
  output logic        load_err
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PresLast = PW'(DIV - 1);

  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
    $error("bcd_time_counter: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  // Upper limit of each of the six low digits, centisecond units upward.
  function automatic logic [3:0] digit_max(input int idx);
    return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
  endfunction

  // A time word is loadable only if it is a reachable display value.
  function automatic logic valid_time(input logic [31:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    if (v[23:20] > 4'd5 || v[15:12] > 4'd5) ok = 1'b0;
    if (v[31:28] > 4'd2 || (v[31:28] == 4'd2 && v[27:24] > 4'd3)) ok = 1'b0;
    return ok;
  endfunction

  logic [PW-1:0] presc_q;
  logic [31:0]   display_q;
  logic          tick_q;
  logic          day_wrap_q;
  logic          load_err_q;
  logic [31:0]   inc_value;
  logic          inc_wrap;
  logic          value_ok;
  logic          presc_last;

  assign value_ok   = valid_time(set_value);
  assign presc_last = (presc_q == PresLast);

  // Ripple the +1 through the digit chain; hours wrap as a pair at 23.
  always_comb begin
    logic       carry;
    logic [3:0] nib;
    carry     = 1'b1;
    nib       = 4'd0;
    inc_value = display_q;
    inc_wrap  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      nib = display_q[i*4 +: 4];
      if (carry) begin
        if (nib == digit_max(i)) begin
          inc_value[i*4 +: 4] = 4'd0;
        end else begin
          inc_value[i*4 +: 4] = nib + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    if (carry) begin
      if (display_q[31:24] == 8'h23) begin
        inc_value[31:24] = 8'h00;
        inc_wrap         = 1'b1;
      end else if (display_q[27:24] == 4'd9) begin
        inc_value[27:24] = 4'd0;
        inc_value[31:28] = display_q[31:28] + 4'd1;
      end else begin
        inc_value[27:24] = display_q[27:24] + 4'd1;
      end
    end
  end

`ifdef ALARM_EN
  logic [31:0] alarm_q;
  logic        alarm_hit_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q     <= '0;
      display_q   <= 32'h0;
      tick_q      <= 1'b0;
      day_wrap_q  <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef ALARM_EN
      alarm_q     <= 32'h0;
      alarm_hit_q <= 1'b0;
`endif
    end else begin
      tick_q      <= 1'b0;
      day_wrap_q  <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef ALARM_EN
      alarm_hit_q <= 1'b0;
`endif
      if (clear) begin
        display_q <= 32'h0;
        presc_q   <= '0;
      end else if (load) begin
        // A rejected load still consumes the edge: nothing advances.
        if (value_ok) begin
          display_q <= set_value;
          presc_q   <= '0;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (run) begin
        if (presc_last) begin
          presc_q    <= '0;
          display_q  <= inc_value;
          tick_q     <= 1'b1;
          day_wrap_q <= inc_wrap;
`ifdef ALARM_EN
          alarm_hit_q <= (inc_value == alarm_q);
`endif
        end else begin
          presc_q <= presc_q + 1'b1;
        end
      end
`ifdef ALARM_EN
      if (!clear && !load && alarm_set) begin
        if (value_ok) alarm_q    <= set_value;
        else          load_err_q <= 1'b1;
      end
`endif
    end
  end

  assign display  = display_q;
  assign tick     = tick_q;
  assign day_wrap = day_wrap_q;
  assign load_err = load_err_q;
`ifdef ALARM_EN
  assign alarm_hit = alarm_hit_q;
`endif

endmodule
